// File: rtl/hynoc_egress_pkg.sv
// Shared types and constants for the egress arbiter.
// No logic; purely declarative.
// Backpressure: n/a.
package hynoc_egress_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int tail_bit(input int flit_width);
        return flit_width - 1;
    endfunction

    // Synthetic tail: only the tail marker set; callers truncate to their flit width.
    function automatic logic [63:0] synth_tail_flit(input int flit_width);
        return 64'd1 << (flit_width - 1);
    endfunction

endpackage

// File: rtl/hynoc_egress_fifo.sv
// Single-clock first-word-fall-through flit FIFO with occupancy.
// Latency: a push is visible on rdata/empty after the writing edge.
// Backpressure: push when full is dropped (drop=1) unless a pop occurs in the same cycle.
module hynoc_egress_fifo
    import hynoc_egress_pkg::*;
#(
    parameter int LOG2_FIFO_DEPTH = 5,
    parameter int FLIT_WIDTH      = 33
) (
    input  logic                     router_clk,
    input  logic                     router_arst_n,
    input  logic                     push,
    input  logic [FLIT_WIDTH-1:0]    wdata,
    input  logic                     pop,
    output logic [FLIT_WIDTH-1:0]    rdata,
    output logic                     empty,
    output logic [LOG2_FIFO_DEPTH:0] level,
    output logic                     drop
);

    localparam int DEPTH = 2**LOG2_FIFO_DEPTH;
    localparam int LW    = LOG2_FIFO_DEPTH + 1;

    logic [FLIT_WIDTH-1:0]      mem [DEPTH];
    logic [LOG2_FIFO_DEPTH-1:0] wr_ptr_q;
    logic [LOG2_FIFO_DEPTH-1:0] rd_ptr_q;
    logic [LW-1:0]              level_q;
    logic                       full;
    logic                       do_pop;
    logic                       do_push;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // The pop frees the slot first, so a push at full with a pop still lands.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign rdata   = mem[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge router_clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge router_clk or negedge router_arst_n) begin
        if (!router_arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/hynoc_egress_arbiter.sv
// Round-robin egress arbiter holding a circuit per packet; optional watchdog via HYNOC_EGRESS_TIMEOUT_EN.
// Latency: grant one edge after request; granted flit reaches FIFO head two edges after its write.
// Backpressure: registered afull to the granted source; writes into a full FIFO drop and flag err_overflow.
module hynoc_egress_arbiter
    import hynoc_egress_pkg::*;
#(
    parameter int NB_PORTS        = 5,
    parameter int FLIT_WIDTH      = 33,
    parameter int LOG2_FIFO_DEPTH = 5,
    parameter int AFULL_MARGIN    = 5,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                                 router_clk,
    input  logic                                 router_arst_n,
    input  logic [NB_PORTS-2:0]                  from_ingress_request,
    input  logic [NB_PORTS-2:0]                  from_ingress_write,
    input  logic [(NB_PORTS-1)*FLIT_WIDTH-1:0]   from_ingress_data,
    output logic [NB_PORTS-2:0]                  to_ingress_grant,
    output logic [NB_PORTS-2:0]                  to_ingress_afull,
    input  logic                                 out_ren,
    output logic [FLIT_WIDTH-1:0]                out_rdata,
    output logic                                 out_rempty,
    output logic [LOG2_FIFO_DEPTH:0]             out_rlevel,
    output logic                                 err_overflow,
    output logic                                 err_stray
`ifdef HYNOC_EGRESS_TIMEOUT_EN
    ,
    output logic                                 err_timeout
`endif
);

    localparam int N     = NB_PORTS - 1;
    localparam int PW    = (N > 1) ? $clog2(N) : 1;
    localparam int DEPTH = 2**LOG2_FIFO_DEPTH;
    localparam int LW    = LOG2_FIFO_DEPTH + 1;
    localparam int TAIL  = tail_bit(FLIT_WIDTH);

    state_t                state_q, state_d;
    logic [N-1:0]          grant_q, grant_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [N-1:0]          afull_q;
    logic                  err_overflow_q;
    logic                  err_stray_q;
    logic                  stg_vld_q, stg_vld_d;
    logic [FLIT_WIDTH-1:0] stg_dat_q, stg_dat_d;

    logic                  pick_vld;
    logic [PW-1:0]         pick_idx;
    logic                  gnt_wr;
    logic [FLIT_WIDTH-1:0] gnt_dat;
    logic                  stray;
    logic                  fifo_drop;
    logic [LW-1:0]         fifo_level;
    logic [PW-1:0]         owner_next;

`ifdef HYNOC_EGRESS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FLIT_WIDTH-1:0] SYNTH_TAIL = FLIT_WIDTH'(synth_tail_flit(FLIT_WIDTH));
    logic [TW-1:0] to_cnt_q;
    logic          to_expired;
    logic          to_room;
    logic          to_fire;
    logic          err_timeout_q;
`endif

    // First requester at or after rr_ptr, wrapping over the N sources.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < N; k++) begin
            int cand;
            cand = int'(rr_ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!pick_vld && from_ingress_request[cand]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(cand);
            end
        end
    end

    assign gnt_wr     = (state_q == BUSY) && from_ingress_write[owner_q];
    assign gnt_dat    = from_ingress_data[int'(owner_q)*FLIT_WIDTH +: FLIT_WIDTH];
    assign stray      = |(from_ingress_write & ~grant_q);
    assign owner_next = (owner_q == PW'(N-1)) ? '0 : owner_q + 1'b1;

`ifdef HYNOC_EGRESS_TIMEOUT_EN
    assign to_expired = (to_cnt_q == TW'(TIMEOUT_CYCLES));
    // Conservative room check: counts the flit still sitting in the staging register.
    assign to_room    = (int'(fifo_level) + int'(stg_vld_q)) < DEPTH;
    assign to_fire    = (state_q == BUSY) && !gnt_wr && to_expired && to_room;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        stg_vld_d = 1'b0;
        stg_dat_d = gnt_dat;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BUSY;
                    grant_d = N'(1) << pick_idx;
                    owner_d = pick_idx;
                end
            end
            BUSY: begin
                if (gnt_wr) begin
                    stg_vld_d = 1'b1;
                    if (gnt_dat[TAIL]) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = owner_next;
                    end
                end
`ifdef HYNOC_EGRESS_TIMEOUT_EN
                else if (to_fire) begin
                    stg_vld_d = 1'b1;
                    stg_dat_d = SYNTH_TAIL;
                    state_d   = IDLE;
                    grant_d   = '0;
                    rr_ptr_d  = owner_next;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge router_clk or negedge router_arst_n) begin
        if (!router_arst_n) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            owner_q        <= '0;
            rr_ptr_q       <= '0;
            afull_q        <= '0;
            err_overflow_q <= 1'b0;
            err_stray_q    <= 1'b0;
            stg_vld_q      <= 1'b0;
            stg_dat_q      <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            owner_q        <= owner_d;
            rr_ptr_q       <= rr_ptr_d;
            afull_q        <= grant_q & {N{fifo_level >= LW'(DEPTH - AFULL_MARGIN)}};
            err_overflow_q <= err_overflow_q | fifo_drop;
            err_stray_q    <= err_stray_q | stray;
            stg_vld_q      <= stg_vld_d;
            stg_dat_q      <= stg_dat_d;
        end
    end

`ifdef HYNOC_EGRESS_TIMEOUT_EN
    always_ff @(posedge router_clk or negedge router_arst_n) begin
        if (!router_arst_n) begin
            to_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            err_timeout_q <= to_fire;
            if (state_q != BUSY || gnt_wr) begin
                to_cnt_q <= '0;
            end else if (!to_expired) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    assign err_timeout = err_timeout_q;
`endif

    hynoc_egress_fifo #(
        .LOG2_FIFO_DEPTH (LOG2_FIFO_DEPTH),
        .FLIT_WIDTH      (FLIT_WIDTH)
    ) u_fifo (
        .router_clk    (router_clk),
        .router_arst_n (router_arst_n),
        .push          (stg_vld_q),
        .wdata         (stg_dat_q),
        .pop           (out_ren),
        .rdata         (out_rdata),
        .empty         (out_rempty),
        .level         (fifo_level),
        .drop          (fifo_drop)
    );

    assign to_ingress_grant = grant_q;
    assign to_ingress_afull = afull_q;
    assign out_rlevel       = fifo_level;
    assign err_overflow     = err_overflow_q;
    assign err_stray        = err_stray_q;

endmodule

// File: tb/tb_hynoc_egress_arbiter.sv
// Directed bench for hynoc_egress_arbiter with a flit scoreboard on the FIFO output.
`timescale 1ns/1ps
module tb_hynoc_egress_arbiter;

    localparam int N     = 4;
    localparam int FW    = 33;
    localparam int DEPTH = 32;

    logic              router_clk = 1'b0;
    logic              router_arst_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      wr = '0;
    logic [N*FW-1:0]   dat = '0;
    logic              out_ren = 1'b0;
    logic [N-1:0]      grant;
    logic [N-1:0]      afull;
    logic [FW-1:0]     out_rdata;
    logic              out_rempty;
    logic [5:0]        out_rlevel;
    logic              err_overflow;
    logic              err_stray;
`ifdef HYNOC_EGRESS_TIMEOUT_EN
    logic              err_timeout;
`endif

    logic [FW-1:0]     exp_q[$];
    int                n_cmp = 0;
    int                n_bad = 0;

    always #5 router_clk = ~router_clk;

    hynoc_egress_arbiter #(
        .NB_PORTS        (5),
        .FLIT_WIDTH      (FW),
        .LOG2_FIFO_DEPTH (5),
        .AFULL_MARGIN    (5),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .router_clk           (router_clk),
        .router_arst_n        (router_arst_n),
        .from_ingress_request (req),
        .from_ingress_write   (wr),
        .from_ingress_data    (dat),
        .to_ingress_grant     (grant),
        .to_ingress_afull     (afull),
        .out_ren              (out_ren),
        .out_rdata            (out_rdata),
        .out_rempty           (out_rempty),
        .out_rlevel           (out_rlevel),
        .err_overflow         (err_overflow),
        .err_stray            (err_stray)
`ifdef HYNOC_EGRESS_TIMEOUT_EN
        ,
        .err_timeout          (err_timeout)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge router_clk);
        #1;
    endtask

    task automatic put(input int src, input logic [FW-1:0] flit, input bit goes_out);
        wr = '0;
        wr[src] = 1'b1;
        dat[src*FW +: FW] = flit;
        if (goes_out) exp_q.push_back(flit);
        tick();
        wr = '0;
    endtask

    task automatic do_reset();
        req = '0;
        wr = '0;
        out_ren = 1'b0;
        router_arst_n = 1'b0;
        exp_q.delete();
        tick();
        tick();
        router_arst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        out_ren = 1'b1;
        while ((exp_q.size() != 0 || !out_rempty) && guard < 200) begin
            tick();
            guard++;
        end
        check({tag, "_drain_in_time"}, 64'(guard < 200), 64'd1);
        check({tag, "_level_after_drain"}, 64'(out_rlevel), 64'd0);
    endtask

    // Scoreboard: every flit leaving the FIFO must be the oldest expected one.
    always @(negedge router_clk) begin
        if (router_arst_n && out_ren && !out_rempty) begin
            check("flit_was_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("out_rdata", 64'(out_rdata), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int order[4];
        bit rise_pending;
        bit rise_done;
        int waited;
        logic [FW-1:0] f;
        order = '{0, 1, 3, 0};

        // Reset values
        tick();
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_afull", 64'(afull), 64'd0);
        check("rst_rempty", 64'(out_rempty), 64'd1);
        check("rst_rlevel", 64'(out_rlevel), 64'd0);
        check("rst_err_overflow", 64'(err_overflow), 64'd0);
        check("rst_err_stray", 64'(err_stray), 64'd0);
        router_arst_n = 1'b1;
        tick();

        // Source 2: header + 40 data + tail, reader always on
        out_ren = 1'b1;
        req = 4'b0100;
        tick();
        check("long_grant", 64'(grant), 64'h4);
        put(2, 33'h0_AAAA0002, 1);
        for (int i = 0; i < 40; i++) put(2, FW'(64'h0_5500_0000 + i), 1);
        req = '0;
        put(2, 33'h1_00000000, 1);
        check("long_grant_released", 64'(grant), 64'd0);
        drain("long");
        check("long_no_stray", 64'(err_stray), 64'd0);
        check("long_no_overflow", 64'(err_overflow), 64'd0);

        // Round robin 0,1,3,0 with one bubble between packets
        do_reset();
        out_ren = 1'b1;
        req = 4'b1011;
        tick();
        for (int p = 0; p < 4; p++) begin
            check($sformatf("rr_grant_%0d", p), 64'(grant), 64'(4'b0001 << order[p]));
            put(order[p], FW'(64'h0_C000_0000 + (p << 8) + 0), 1);
            put(order[p], FW'(64'h0_C000_0000 + (p << 8) + 1), 1);
            if (p == 3) req = '0;
            put(order[p], FW'(64'h1_C000_0000 + (p << 8) + 2), 1);
            check($sformatf("rr_bubble_%0d", p), 64'(grant), 64'd0);
            tick();
        end
        check("rr_idle_after_last", 64'(grant), 64'd0);
        drain("rr");

        // Stray write from source 3 while source 0 owns the output
        req = 4'b0001;
        tick();
        check("stray_grant", 64'(grant), 64'h1);
        req = '0;
        check("stray_flag_before", 64'(err_stray), 64'd0);
        put(3, 33'h0_DEADBEEF, 0);
        check("stray_flag", 64'(err_stray), 64'd1);
        check("stray_grant_kept", 64'(grant), 64'h1);
        put(0, 33'h1_00000055, 1);
        check("stray_grant_released", 64'(grant), 64'd0);
        drain("stray");

        // Overflow and afull with the reader stopped
        do_reset();
        check("ovf_stray_cleared", 64'(err_stray), 64'd0);
        req = 4'b0010;
        tick();
        check("ovf_grant", 64'(grant), 64'h2);
        req = '0;
        rise_pending = 1'b0;
        rise_done = 1'b0;
        for (int i = 0; i < 33; i++) begin
            f = (i == 32) ? FW'(64'h1_0000_1000 + i) : FW'(64'h0_0000_1000 + i);
            put(1, f, i < DEPTH);
            if (rise_pending) begin
                check("afull_rises", 64'(afull), 64'h2);
                rise_pending = 1'b0;
                rise_done = 1'b1;
            end else if (!rise_done && out_rlevel == 6'd27) begin
                check("afull_lags_level", 64'(afull), 64'd0);
                rise_pending = 1'b1;
            end
        end
        check("afull_rise_seen", 64'(rise_done), 64'd1);
        check("ovf_full_level", 64'(out_rlevel), 64'd32);
        check("ovf_flag_not_yet", 64'(err_overflow), 64'd0);
        check("ovf_grant_released", 64'(grant), 64'd0);
        tick();
        check("ovf_flag", 64'(err_overflow), 64'd1);
        check("ovf_level_held", 64'(out_rlevel), 64'd32);
        check("ovf_afull_masked", 64'(afull), 64'd0);
        drain("ovf");

        // Reset mid-packet with ten flits buffered
        out_ren = 1'b0;
        req = 4'b0100;
        tick();
        check("mid_grant", 64'(grant), 64'h4);
        req = '0;
        for (int i = 0; i < 10; i++) begin
            put(2, FW'(64'h0_7700_0000 + i), 0);
            if (i == 4) put(0, 33'h0_0BADF00D, 0);
        end
        tick();
        tick();
        check("mid_level", 64'(out_rlevel), 64'd10);
        check("mid_stray_set", 64'(err_stray), 64'd1);
        router_arst_n = 1'b0;
        #1;
        check("mid_rst_rempty", 64'(out_rempty), 64'd1);
        check("mid_rst_level", 64'(out_rlevel), 64'd0);
        check("mid_rst_grant", 64'(grant), 64'd0);
        check("mid_rst_afull", 64'(afull), 64'd0);
        check("mid_rst_stray", 64'(err_stray), 64'd0);
        check("mid_rst_overflow", 64'(err_overflow), 64'd0);
        tick();
        router_arst_n = 1'b1;
        req = 4'b1010;
        tick();
        check("mid_regrant_from_ptr0", 64'(grant), 64'h2);
        req = '0;
        put(1, 33'h1_0000ABCD, 1);
        check("mid_tail_release", 64'(grant), 64'd0);
        drain("mid");

`ifdef HYNOC_EGRESS_TIMEOUT_EN
        // Watchdog releases a stalled source
        out_ren = 1'b1;
        req = 4'b0010;
        tick();
        check("to_grant", 64'(grant), 64'h2);
        req = '0;
        put(1, 33'h0_00000111, 1);
        put(1, 33'h0_00000222, 1);
        exp_q.push_back(33'h1_00000000);
        waited = 0;
        while (!err_timeout && waited < 40) begin
            tick();
            waited++;
        end
        check("to_pulse_seen", 64'(err_timeout), 64'd1);
        check("to_wait_at_least_limit", 64'(waited >= 16), 64'd1);
        check("to_grant_dropped", 64'(grant), 64'd0);
        tick();
        check("to_pulse_one_cycle", 64'(err_timeout), 64'd0);
        drain("to");
`else
        waited = 0;
`endif

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hynoc_egress_arbiter.md
# hynoc_egress_arbiter

Router output-side stage that consumes the request/write/data streams produced by the per-port ingress stages, which sit directly upstream. It arbitrates round-robin among the NB_PORTS-1 ingress sources that may target this output and holds a circuit to the winner until its tail flit. It buffers the granted flits in an internal FIFO and returns grant and almost-full back-pressure to the ingress stages. A single router clock domain is used throughout.

## Interface
- NB_PORTS, 5: router ports; the arbiter serves NB_PORTS-1 sources (N below).
- FLIT_WIDTH, 33: flit width; bit FLIT_WIDTH-1 is the tail marker.
- LOG2_FIFO_DEPTH, 5: output FIFO depth is 2**LOG2_FIFO_DEPTH.
- AFULL_MARGIN, 5: afull is asserted when level >= depth-AFULL_MARGIN.
- TIMEOUT_CYCLES, 256: watchdog limit; used only with the macro.

Ports:
- router_clk  in  1  router clock
- router_arst_n  in  1  asynchronous reset, active-low
- from_ingress_request  in  N  one request bit per source
- from_ingress_write  in  N  per-source write strobe
- from_ingress_data  in  N*FLIT_WIDTH  source i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH]
- to_ingress_grant  out  N  one-hot or zero
- to_ingress_afull  out  N  almost-full, masked by the grant
- out_ren  in  1  FIFO read enable
- out_rdata  out  FLIT_WIDTH  FIFO head, valid when out_rempty=0
- out_rempty  out  1  FIFO empty
- out_rlevel  out  LOG2_FIFO_DEPTH+1  FIFO occupancy
- err_overflow  out  1  sticky; a write arrived while the FIFO was full
- err_stray  out  1  sticky; a write arrived from a non-granted source

## Operation
- FSM has two states: IDLE and BUSY. Reset state is IDLE.
- IDLE, with any request bit set: select the first requesting source at or after rr_ptr, wrapping. Register grant to that source and go to BUSY.
- BUSY: the write from the granted source is pushed into the FIFO. A granted write with bit FLIT_WIDTH-1 set is the tail. On the tail, clear the grant, set rr_ptr to owner+1 mod N, and go to IDLE.
- BUSY ignores request changes. Deasserting the request mid-packet does not release the grant.
- Writes from non-granted sources and writes in IDLE are dropped and set err_stray.
- A write while the FIFO is full is dropped and sets err_overflow. A tail dropped this way still releases the grant.
- to_ingress_afull = grant & {N{level >= 2**LOG2_FIFO_DEPTH - AFULL_MARGIN}}, registered.
- A simultaneous push and pop at full or empty is legal. When full, out_ren is applied first, so the push is accepted.
- Sticky error flags clear only on reset.
- Reset values: grant 0, afull 0, out_rempty 1, out_rlevel 0, both error flags 0, rr_ptr 0. out_rdata is undefined when the FIFO is empty.
- Reset asserted mid-packet flushes the FIFO and returns to IDLE with no tail emitted.

## Timing
- Request sampled at edge k produces grant visible after edge k+1.
- The tail write is accepted at edge t. Grant is low after t. The earliest re-grant is visible after t+1, so there is one bubble cycle per packet.
- Push to read latency: a flit written at edge k clears out_rempty after edge k+1. out_rdata is presented first-word-fall-through.
- afull tracks the level with one cycle of lag. AFULL_MARGIN >= 3 covers ingress reaction time.

## Configuration
- HYNOC_EGRESS_TIMEOUT_EN defined: in BUSY, a counter increments on every cycle without a granted write and resets on each granted write.
  - When it reaches TIMEOUT_CYCLES, the arbiter pushes a synthetic tail {1'b1, {FLIT_WIDTH-1{1'b0}}}. If the FIFO is full, it waits until space is available.
  - It then releases the grant and pulses err_timeout (1 cycle).
  - err_timeout is an extra 1-bit output present only with the macro.
- Macro undefined: no counter and no err_timeout port. The grant is held indefinitely until the tail.

## Structure
- Package hynoc_egress_pkg holds:
  - the state enum (IDLE, BUSY);
  - the TAIL_BIT index function;
  - the synthetic tail flit constant.
- Sub-module hynoc_egress_fifo: single-clock, first-word-fall-through, with level, parameters LOG2_FIFO_DEPTH and FLIT_WIDTH.
- Arbitration and FSM stay in the top level.

## Test plan
- Source 2 requests and sends header plus 40 data flits plus tail 0x1_00000000, with out_ren always 1. Expected: grant=4'b0100 one cycle after the request, 42 flits out in order, grant=0 after the tail.
- Sources 0, 1, 3 request continuously with 3-flit packets. Expected: grants in order 0, 1, 3, 0, with exactly one idle cycle between packets.
- out_ren=0 while source 1 streams. Expected: afull[1] rises when level reaches 27 (depth 32, margin 5). The 33rd write sets err_overflow and no data is corrupted.
- Source 0 is granted while source 3 writes 0x0_DEADBEEF. Expected: err_stray=1 and the flit is absent from the FIFO.
- Reset pulsed mid-packet with level=10. Expected: out_rempty=1, grant=0, flags 0, and the next request is served normally.
- With HYNOC_EGRESS_TIMEOUT_EN and TIMEOUT_CYCLES=16: granted source 1 sends 2 flits then stalls. Expected: after 16 cycles a tail 0x1_00000000 is pushed, err_timeout pulses, and grant drops.
